macro_fsm: RTL and testbench

// - Two-road (A/B) traffic-light controller for one intersection; road A is the priority road.
// - Sequences the green/amber/red phases and pedestrian all-red phases, plus a flashing-amber mode.
// - Times every phase with an external down-counter: the controller loads it with INICIO/data and waits for FIN.

---
 rtl/macro_fsm_pkg.sv | 38 +++
 rtl/macro_fsm_lamps.sv | 38 +++
 rtl/macro_fsm.sv | 174 +++++++++++++++++
 tb/tb_macro_fsm.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/macro_fsm_pkg.sv
// Shared definitions for the macro_fsm traffic-light controller.
// Contents:
//   state_e      controller phases
//   T_*          timer load values per phase (timer units)
//   phase_time() timer load value for a given phase
package macro_fsm_pkg;

  typedef enum logic [3:0] {
    INIT  = 4'd0,
    A_GRN = 4'd1,
    A_AMB = 4'd2,
    AR_AB = 4'd3,
    B_GRN = 4'd4,
    B_AMB = 4'd5,
    AR_BA = 4'd6,
    PED   = 4'd7,
    FLASH = 4'd8
  } state_e;

  localparam logic [3:0] T_ALLRED = 4'd1;
  localparam logic [3:0] T_GREEN  = 4'd10;
  localparam logic [3:0] T_AMBER  = 4'd3;
  localparam logic [3:0] T_PED    = 4'd8;
  localparam logic [3:0] T_FLASH  = 4'd1;

  function automatic logic [3:0] phase_time(input state_e s);
    logic [3:0] t;
    case (s)
      A_GRN, B_GRN: t = T_GREEN;
      A_AMB, B_AMB: t = T_AMBER;
      PED:          t = T_PED;
      FLASH:        t = T_FLASH;
      default:      t = T_ALLRED;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/macro_fsm_lamps.sv
// Lamp decoder: maps the controller phase to the six lamp outputs.
// Ports:
//   state_i       current phase
//   blink_i       flash blink bit (drives both ambers in FLASH)
//   verde_*_o     green lamps, road A/B
//   amarillo_*_o  amber lamps, road A/B
//   rojo_*_o      red lamps, road A/B
module macro_fsm_lamps
  import macro_fsm_pkg::*;
(
  input  state_e state_i,
  input  logic   blink_i,
  output logic   verde_a_o,
  output logic   amarillo_a_o,
  output logic   rojo_a_o,
  output logic   verde_b_o,
  output logic   amarillo_b_o,
  output logic   rojo_b_o
);

  // Vector order: {green A, amber A, red A, green B, amber B, red B}
  logic [5:0] lamps;

  always_comb begin
    lamps = 6'b001_001;  // all-red phases (INIT, AR_AB, AR_BA, PED)
    case (state_i)
      A_GRN:   lamps = 6'b100_001;
      A_AMB:   lamps = 6'b010_001;
      B_GRN:   lamps = 6'b001_100;
      B_AMB:   lamps = 6'b001_010;
      FLASH:   lamps = {1'b0, blink_i, 1'b0, 1'b0, blink_i, 1'b0};
      default: lamps = 6'b001_001;
    endcase
  end

  assign {verde_a_o, amarillo_a_o, rojo_a_o, verde_b_o, amarillo_b_o, rojo_b_o} = lamps;

endmodule

// File: rtl/macro_fsm.sv
// Two-road traffic-light controller (road A has priority) with pedestrian
// all-red phase and flashing-amber mode. Every phase is timed by an external
// down-counter: the controller pulses INICIO with the load value on data and
// waits for FIN.
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   FIN                   timer done pulse (ignored while INICIO is high)
//   iFFT                  flash-mode request
//   SensorA/SensorB       vehicle presence
//   PasoA/PasoB           pedestrian buttons
//   data, INICIO          timer load value and start strobe
//   oFFT                  blink bit
//   VerdeX/AmarilloX/RojoX lamps
// Configuration: define MACRO_FSM_PED_EN to build the pedestrian latches and
// the PED phase; without it PasoA/PasoB are ignored.
module macro_fsm
  import macro_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       FIN,
  input  logic       iFFT,
  input  logic       SensorA,
  input  logic       SensorB,
  input  logic       PasoA,
  input  logic       PasoB,
  output logic [3:0] data,
  output logic       oFFT,
  output logic       VerdeA,
  output logic       VerdeB,
  output logic       AmarilloA,
  output logic       AmarilloB,
  output logic       RojoA,
  output logic       RojoB,
  output logic       INICIO
);

  state_e     state_q, state_d;
  logic       inicio_q, inicio_d;
  logic [3:0] data_q, data_d;
  logic       oFFT_q, oFFT_d;
  logic       last_b_q, last_b_d;  // 1: road B held the most recent green
  logic       started_q;           // first timer load after reset done
  logic       fin_ok, arm, ped_any;

  // A FIN in the same cycle as the strobe belongs to the previous load.
  assign fin_ok = FIN && !inicio_q;

`ifdef MACRO_FSM_PED_EN
  logic ped_a_q, ped_a_d, ped_b_q, ped_b_d;
  logic pend_a_q, pend_a_d, pend_b_q, pend_b_d;  // presses made during PED
  logic ped_done;

  assign ped_any  = ped_a_q | ped_b_q;
  assign ped_done = (state_q == PED) && fin_ok && !iFFT;

  always_comb begin
    // Completing PED serves the latched requests; presses made while the
    // crossing was running survive for the next pedestrian phase.
    if (ped_done) begin
      ped_a_d = pend_a_q | PasoA;
      ped_b_d = pend_b_q | PasoB;
    end else begin
      ped_a_d = ped_a_q | PasoA;
      ped_b_d = ped_b_q | PasoB;
    end
    if (state_d == PED) begin
      pend_a_d = ((state_q == PED) ? pend_a_q : 1'b0) | PasoA;
      pend_b_d = ((state_q == PED) ? pend_b_q : 1'b0) | PasoB;
    end else begin
      pend_a_d = 1'b0;
      pend_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ped_a_q  <= 1'b0;
      ped_b_q  <= 1'b0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
    end else begin
      ped_a_q  <= ped_a_d;
      ped_b_q  <= ped_b_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
    end
  end
`else
  logic unused_paso;
  assign unused_paso = PasoA ^ PasoB;
  assign ped_any     = 1'b0;
`endif

  // Next-state logic. Flash request pre-empts everything, including FIN.
  always_comb begin
    state_d = state_q;
    arm     = 1'b0;
    if (iFFT && (state_q != FLASH)) begin
      state_d = FLASH;
      arm     = 1'b1;
    end else if ((state_q == INIT) && !started_q) begin
      arm = 1'b1;
    end else if (fin_ok) begin
      arm = 1'b1;  // every accepted FIN either moves on or re-arms
      case (state_q)
        INIT:    state_d = A_GRN;
        A_GRN:   if (SensorB || ped_any) state_d = A_AMB;
        A_AMB:   state_d = AR_AB;
        AR_AB:   state_d = ped_any ? PED : B_GRN;
        B_GRN:   if (SensorA || !SensorB || ped_any) state_d = B_AMB;
        B_AMB:   state_d = AR_BA;
        AR_BA:   state_d = ped_any ? PED : A_GRN;
        PED:     state_d = last_b_q ? A_GRN : B_GRN;
        FLASH:   if (!iFFT) state_d = INIT;
        default: state_d = INIT;
      endcase
    end
  end

  // Registered strobe, load value, blink bit and last-green memory.
  always_comb begin
    inicio_d = arm;
    data_d   = arm ? phase_time(state_d) : data_q;
    if (state_d != FLASH) begin
      oFFT_d = 1'b0;
    end else if ((state_q == FLASH) && fin_ok) begin
      oFFT_d = ~oFFT_q;
    end else begin
      oFFT_d = oFFT_q;
    end
    if (state_d == B_GRN) begin
      last_b_d = 1'b1;
    end else if (state_d == A_GRN) begin
      last_b_d = 1'b0;
    end else begin
      last_b_d = last_b_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= INIT;
      inicio_q  <= 1'b0;
      data_q    <= 4'd0;
      oFFT_q    <= 1'b0;
      last_b_q  <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inicio_q  <= inicio_d;
      data_q    <= data_d;
      oFFT_q    <= oFFT_d;
      last_b_q  <= last_b_d;
      started_q <= 1'b1;
    end
  end

  assign INICIO = inicio_q;
  assign data   = data_q;
  assign oFFT   = oFFT_q;

  macro_fsm_lamps u_lamps (
    .state_i      (state_q),
    .blink_i      (oFFT_q),
    .verde_a_o    (VerdeA),
    .amarillo_a_o (AmarilloA),
    .rojo_a_o     (RojoA),
    .verde_b_o    (VerdeB),
    .amarillo_b_o (AmarilloB),
    .rojo_b_o     (RojoB)
  );

endmodule

// File: tb/tb_macro_fsm.sv
// Self-checking bench for macro_fsm: directed scenarios followed by random
// stimulus, all compared cycle by cycle against a phase-level reference model.
module tb_macro_fsm;

`ifdef MACRO_FSM_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  // Reference-model phase numbering (independent of the design's encoding).
  localparam int P_INIT = 0, P_AGRN = 1, P_AAMB = 2, P_ARAB = 3, P_BGRN = 4;
  localparam int P_BAMB = 5, P_ARBA = 6, P_PED = 7, P_FLASH = 8;
  localparam int T_TAB [9] = '{1, 10, 3, 1, 10, 3, 1, 8, 1};
  // {green A, amber A, red A, green B, amber B, red B}
  localparam logic [5:0] L_TAB [9] = '{6'b001001, 6'b100001, 6'b010001, 6'b001001,
                                       6'b001100, 6'b001010, 6'b001001, 6'b001001,
                                       6'b000000};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       FIN = 1'b0, iFFT = 1'b0, SensorA = 1'b0, SensorB = 1'b0;
  logic       PasoA = 1'b0, PasoB = 1'b0;
  logic [3:0] data;
  logic       oFFT, VerdeA, VerdeB, AmarilloA, AmarilloB, RojoA, RojoB, INICIO;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int         m_phase;
  bit         m_inicio, m_booted, m_blink, m_lastB;
  bit         m_pedA, m_pedB, m_pendA, m_pendB;
  logic [3:0] m_data;

  macro_fsm dut (
    .clk(clk), .rst(rst), .FIN(FIN), .iFFT(iFFT), .SensorA(SensorA), .SensorB(SensorB),
    .PasoA(PasoA), .PasoB(PasoB), .data(data), .oFFT(oFFT), .VerdeA(VerdeA),
    .VerdeB(VerdeB), .AmarilloA(AmarilloA), .AmarilloB(AmarilloB), .RojoA(RojoA),
    .RojoB(RojoB), .INICIO(INICIO)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] lamps_obs();
    return {VerdeA, AmarilloA, RojoA, VerdeB, AmarilloB, RojoB};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_INIT; m_inicio = 0; m_booted = 0; m_blink = 0; m_lastB = 0;
    m_pedA = 0; m_pedB = 0; m_pendA = 0; m_pendB = 0; m_data = 4'd0;
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_lamps"}, 32'(lamps_obs()), 32'(6'b001001));
    check_val({tag, "_INICIO"}, 32'(INICIO), 0);
    check_val({tag, "_data"}, 32'(data), 0);
    check_val({tag, "_oFFT"}, 32'(oFFT), 0);
  endtask

  // One clock cycle: drive inputs, advance the model, compare everything.
  task automatic cycle(input bit fin, input bit ff, input bit sa, input bit sb,
                       input bit pa, input bit pb);
    bit fin_v, arm, ped, done;
    int nxt;
    logic [5:0] exp_l;
    FIN = fin; iFFT = ff; SensorA = sa; SensorB = sb; PasoA = pa; PasoB = pb;

    fin_v = fin && !m_inicio;
    ped   = PED_EN && (m_pedA || m_pedB);
    arm = 0; done = 0; nxt = m_phase;
    if (ff && m_phase != P_FLASH) begin
      nxt = P_FLASH; arm = 1;
    end else if (m_phase == P_INIT && !m_booted) begin
      arm = 1;
    end else if (fin_v) begin
      arm = 1;
      case (m_phase)
        P_INIT:  nxt = P_AGRN;
        P_AGRN:  nxt = (sb || ped) ? P_AAMB : P_AGRN;
        P_AAMB:  nxt = P_ARAB;
        P_ARAB:  nxt = ped ? P_PED : P_BGRN;
        P_BGRN:  nxt = (sa || !sb || ped) ? P_BAMB : P_BGRN;
        P_BAMB:  nxt = P_ARBA;
        P_ARBA:  nxt = ped ? P_PED : P_AGRN;
        P_PED:   begin nxt = m_lastB ? P_AGRN : P_BGRN; done = 1; end
        default: nxt = ff ? P_FLASH : P_INIT;
      endcase
    end
    if (nxt != P_FLASH) m_blink = 0;
    else if (m_phase == P_FLASH && fin_v) m_blink = !m_blink;
    if (done) begin
      m_pedA = m_pendA | pa; m_pedB = m_pendB | pb;
    end else begin
      m_pedA = m_pedA | pa;  m_pedB = m_pedB | pb;
    end
    if (nxt == P_PED) begin
      m_pendA = ((m_phase == P_PED) ? m_pendA : 1'b0) | pa;
      m_pendB = ((m_phase == P_PED) ? m_pendB : 1'b0) | pb;
    end else begin
      m_pendA = 0; m_pendB = 0;
    end
    if (nxt == P_AGRN) m_lastB = 0;
    if (nxt == P_BGRN) m_lastB = 1;
    m_booted = 1;
    m_inicio = arm;
    if (arm) m_data = T_TAB[nxt][3:0];
    m_phase = nxt;

    @(posedge clk); #1;
    FIN = 0; PasoA = 0; PasoB = 0;

    exp_l = (m_phase == P_FLASH) ? {1'b0, m_blink, 1'b0, 1'b0, m_blink, 1'b0} : L_TAB[m_phase];
    check_val("INICIO", 32'(INICIO), 32'(m_inicio));
    check_val("data", 32'(data), 32'(m_data));
    check_val("oFFT", 32'(oFFT), 32'(m_blink));
    check_val("lamps", 32'(lamps_obs()), 32'(exp_l));
    if (m_phase != P_FLASH) begin
      check_val("one_lamp_A", int'(VerdeA) + int'(AmarilloA) + int'(RojoA), 1);
      check_val("one_lamp_B", int'(VerdeB) + int'(AmarilloB) + int'(RojoB), 1);
      check_val("no_two_greens", 32'(VerdeA & VerdeB), 0);
    end
    if (INICIO)
      $display("[%0t] load phase=%0d data=%0d lamps=%b oFFT=%b", $time, m_phase, data,
               lamps_obs(), oFFT);
  endtask

  initial begin
    bit ff, sa, sb;
    model_reset();

    // Reset held for 5 clocks with a car waiting on road A.
    SensorA = 1'b1;
    #1 rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check_reset_values("reset");
    end
    rst = 1'b1;

    // Boot: INIT load, then A_GRN.
    cycle(0, 0, 1, 0, 0, 0);
    check_val("boot_data", 32'(data), 1);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    check_val("agrn_verde", 32'(VerdeA & RojoB), 1);
    check_val("agrn_data", 32'(data), 10);

    // No demand on B: green re-armed.
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check_val("rearm_inicio", 32'(INICIO), 1);
    check_val("rearm_verde", 32'(VerdeA), 1);

    // Demand on B: A_AMB, AR_AB, B_GRN.
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    check_val("aamb_data", 32'(data), 3);
    check_val("aamb_lamp", 32'(AmarilloA), 1);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    check_val("arab_red", 32'(RojoA & RojoB), 1);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    check_val("bgrn_verde", 32'(VerdeB), 1);
    check_val("bgrn_data", 32'(data), 10);

    // Back to A via car on A.
    cycle(0, 0, 1, 1, 0, 0);
    cycle(1, 0, 1, 1, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);

    // Pedestrian press on B during A_GRN, no vehicle demand.
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0);
`ifdef MACRO_FSM_PED_EN
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check_val("ped_data", 32'(data), 8);
    check_val("ped_red", 32'(RojoA & RojoB), 1);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check_val("ped_to_bgrn", 32'(VerdeB), 1);
`else
    check_val("noped_rearm", 32'(INICIO & VerdeA), 1);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
`endif

    // Flash mode from B_GRN.
    cycle(0, 1, 0, 1, 0, 0);
    check_val("flash_greens", 32'(VerdeA | VerdeB), 0);
    check_val("flash_ambers", 32'(AmarilloA | AmarilloB), 0);
    check_val("flash_data", 32'(data), 1);
    cycle(0, 1, 0, 1, 0, 0);
    cycle(1, 1, 0, 1, 0, 0);
    check_val("flash_on", 32'(AmarilloA & AmarilloB), 1);
    cycle(0, 1, 0, 1, 0, 0);
    cycle(1, 1, 0, 1, 0, 0);
    check_val("flash_off", 32'(AmarilloA | AmarilloB), 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    check_val("flash_exit", 32'(RojoA & RojoB), 1);

    // FIN coinciding with INICIO is ignored.
    cycle(1, 0, 0, 0, 0, 0);
    check_val("fin_ign_inicio", 32'(INICIO), 0);
    check_val("fin_ign_state", 32'(RojoA & !VerdeA), 1);
    cycle(1, 0, 0, 0, 0, 0);

    // Reset asserted mid-operation takes effect without a clock edge.
    #2 rst = 1'b0;
    #1 check_reset_values("midreset");
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();

    // Randomized traffic.
    ff = 0; sa = 0; sb = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) sa = !sa;
      if ($urandom_range(0, 7) == 0) sb = !sb;
      if (!ff && $urandom_range(0, 79) == 0) ff = 1;
      else if (ff && $urandom_range(0, 9) == 0) ff = 0;
      cycle($urandom_range(0, 2) == 0, ff, sa, sb,
            $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
